// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// Module  : pc_fetch_if
// Brief   : Strobe, program-memory and status bundle between decoder/memory
//           side (master) and the fetch unit (slave).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_if #(
  parameter int PC_WIDTH    = 13,
  parameter int STACK_DEPTH = 8
);
  localparam int c_DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic                 pc_incr_en;
  logic                 pc_j_en;
  logic                 pc_call_en;
  logic                 pc_ret_en;
  logic                 pcl_wr_en;
  logic [7:0]           pcl_wr_data;
  logic [4:0]           pclath;
  logic                 instr_rd_en;
  logic                 instr_flush;
  logic [PC_WIDTH-1:0]  prog_addr;
  logic [13:0]          prog_data;
  logic [13:0]          instr_current;
  logic [PC_WIDTH-1:0]  pc;
  logic [c_DEPTH_W-1:0] stack_depth;
  logic                 stack_ovf;
  logic                 stack_unf;

  modport master (
    output pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data,
           pclath, instr_rd_en, instr_flush, prog_data,
    input  prog_addr, instr_current, pc, stack_depth, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data,
           pclath, instr_rd_en, instr_flush, prog_data,
    output prog_addr, instr_current, pc, stack_depth, stack_ovf, stack_unf
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// Module  : pc_fetch_unit
// Brief   : PIC16F program counter, circular return stack and instruction
//           register feeding the instruction decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
  parameter int                PC_WIDTH     = 13,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h000,
  parameter logic [13:0]       NOP_WORD     = 14'h0000
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pc_fetch_if.slave  bus
);

  localparam int c_SP_W    = $clog2(STACK_DEPTH);
  localparam int c_DEPTH_W = c_SP_W + 1;
  localparam logic [c_DEPTH_W-1:0] c_FULL = c_DEPTH_W'(STACK_DEPTH);

  logic [PC_WIDTH-1:0]  r_pc;
  logic [13:0]          r_ir;
  logic [c_SP_W-1:0]    r_sp;
  logic [c_DEPTH_W-1:0] r_depth;
  logic                 r_ovf;
  logic                 r_unf;
  logic [PC_WIDTH-1:0]  r_stack [STACK_DEPTH];

  logic                 w_pop;
  logic                 w_push;
  logic [c_SP_W-1:0]    w_sp_dec;
  logic [PC_WIDTH-1:0]  w_jump_target;
  logic [PC_WIDTH-1:0]  w_pcl_target;
  logic [PC_WIDTH-1:0]  w_pc_next;
  logic [13:0]          w_ir_next;

  // A return on the same edge as a call suppresses the push entirely.
  assign w_pop         = bus.pc_ret_en;
  assign w_push        = bus.pc_call_en & bus.pc_j_en & ~bus.pc_ret_en;
  assign w_sp_dec      = r_sp - c_SP_W'(1);
  assign w_jump_target = PC_WIDTH'({bus.pclath[4:3], r_ir[10:0]});
  assign w_pcl_target  = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});

  always_comb begin
    w_pc_next = r_pc;
    if (w_pop) begin
      w_pc_next = r_stack[w_sp_dec];
    end else if (bus.pc_j_en) begin
      w_pc_next = w_jump_target;
    end else if (bus.pcl_wr_en) begin
      w_pc_next = w_pcl_target;
    end else if (bus.pc_incr_en) begin
      w_pc_next = r_pc + PC_WIDTH'(1);
    end
  end

  always_comb begin
    w_ir_next = r_ir;
    if (bus.instr_flush) begin
      w_ir_next = NOP_WORD;
    end else if (bus.instr_rd_en) begin
      w_ir_next = bus.prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
      r_ir <= NOP_WORD;
    end else begin
      r_pc <= w_pc_next;
      r_ir <= w_ir_next;
    end
  end

  // Depth saturates at both ends while sp keeps wrapping, so an overflow
  // overwrites the oldest entry and an underflow re-reads a stale one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_pop) begin
      r_sp <= w_sp_dec;
      if (r_depth == '0) begin
        r_unf <= 1'b1;
      end else begin
        r_depth <= r_depth - c_DEPTH_W'(1);
      end
    end else if (w_push) begin
      r_sp <= r_sp + c_SP_W'(1);
      if (r_depth == c_FULL) begin
        r_ovf <= 1'b1;
      end else begin
        r_depth <= r_depth + c_DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp] <= r_pc;
    end
  end

  assign bus.prog_addr     = r_pc;
  assign bus.pc            = r_pc;
  assign bus.instr_current = r_ir;
  assign bus.stack_depth   = r_depth;
  assign bus.stack_ovf     = r_ovf;
  assign bus.stack_unf     = r_unf;

endmodule

`default_nettype wire
